// File: rtl/mem_rsp_credit_buffer_if.sv
// rtl/mem_rsp_credit_buffer_if.sv - requester/interconnect signal bundle for mem_rsp_credit_buffer
// slave is the buffer's view, master the view of whoever drives both sides of it.
interface mem_rsp_credit_buffer_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
);
  logic                   in_req_valid_i;
  logic                   in_req_ready_o;
  logic [AddrWidth-1:0]   in_req_addr_i;
  logic                   in_req_we_i;
  logic [DataWidth-1:0]   in_req_wdata_i;
  logic [DataWidth/8-1:0] in_req_strb_i;
  logic                   in_rsp_valid_o;
  logic                   in_rsp_ready_i;
  logic [DataWidth-1:0]   in_rsp_rdata_o;
  logic                   out_req_valid_o;
  logic                   out_req_gnt_i;
  logic [AddrWidth-1:0]   out_req_addr_o;
  logic                   out_req_we_o;
  logic [DataWidth-1:0]   out_req_wdata_o;
  logic [DataWidth/8-1:0] out_req_strb_o;
  logic                   out_rsp_valid_i;
  logic [DataWidth-1:0]   out_rsp_rdata_i;

  modport slave (
    input  in_req_valid_i, in_req_addr_i, in_req_we_i, in_req_wdata_i, in_req_strb_i,
    output in_req_ready_o,
    output in_rsp_valid_o, in_rsp_rdata_o,
    input  in_rsp_ready_i,
    output out_req_valid_o, out_req_addr_o, out_req_we_o, out_req_wdata_o, out_req_strb_o,
    input  out_req_gnt_i,
    input  out_rsp_valid_i, out_rsp_rdata_i
  );

  modport master (
    output in_req_valid_i, in_req_addr_i, in_req_we_i, in_req_wdata_i, in_req_strb_i,
    input  in_req_ready_o,
    input  in_rsp_valid_o, in_rsp_rdata_o,
    output in_rsp_ready_i,
    input  out_req_valid_o, out_req_addr_o, out_req_we_o, out_req_wdata_o, out_req_strb_o,
    output out_req_gnt_i,
    output out_rsp_valid_i, out_rsp_rdata_i
  );
endinterface

// File: rtl/mem_rsp_credit_buffer.sv
// rtl/mem_rsp_credit_buffer.sv - credit-gated in-order read response buffer
// Optional MEM_RSP_BUF_FALLTHROUGH_EN: zero-latency bypass when the FIFO is empty.
module mem_rsp_credit_buffer #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int Depth     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mem_rsp_credit_buffer_if.slave bus,
  output logic                  err_o
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, inflight_q;
  logic                 err_q;

  logic [CntW:0]        used;
  logic                 credit_ok;
  logic                 fifo_empty;
  logic                 read_grant;
  logic                 rsp_ok;
  logic                 rsp_unexpected;
  logic                 push;
  logic                 pop;
  logic                 bypass;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots held by queued data plus slots reserved by reads still in flight.
  assign used       = {1'b0, count_q} + {1'b0, inflight_q};
  assign credit_ok  = used < (CntW + 1)'(Depth);
  assign fifo_empty = (count_q == '0);

  assign bus.out_req_valid_o = bus.in_req_valid_i & (bus.in_req_we_i | credit_ok);
  assign bus.in_req_ready_o  = bus.out_req_valid_o & bus.out_req_gnt_i;
  assign bus.out_req_addr_o  = AddrWidth'(bus.in_req_addr_i);
  assign bus.out_req_we_o    = bus.in_req_we_i;
  assign bus.out_req_wdata_o = bus.in_req_wdata_i;
  assign bus.out_req_strb_o  = bus.in_req_strb_i;

  assign read_grant     = bus.in_req_ready_o & ~bus.in_req_we_i;
  assign rsp_ok         = bus.out_rsp_valid_i & (inflight_q != '0);
  assign rsp_unexpected = bus.out_rsp_valid_i & (inflight_q == '0);

`ifdef MEM_RSP_BUF_FALLTHROUGH_EN
  assign bypass             = fifo_empty & rsp_ok & bus.in_rsp_ready_i;
  assign bus.in_rsp_valid_o = ~fifo_empty | rsp_ok;
  assign bus.in_rsp_rdata_o = fifo_empty ? bus.out_rsp_rdata_i : mem_q[rd_ptr_q];
`else
  assign bypass             = 1'b0;
  assign bus.in_rsp_valid_o = ~fifo_empty;
  assign bus.in_rsp_rdata_o = mem_q[rd_ptr_q];
`endif

  assign push = rsp_ok & ~bypass;
  assign pop  = ~fifo_empty & bus.in_rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q    <= count_q + CntW'(push) - CntW'(pop);
      inflight_q <= inflight_q + CntW'(read_grant) - CntW'(rsp_ok);
      if (rsp_unexpected) err_q <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.out_rsp_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!rsp_unexpected)
        else $warning("mem_rsp_credit_buffer: read response with nothing outstanding");
    end
  end

  assign err_o = err_q;

endmodule
